// File: rtl/adder_ctrl_pkg.sv
// adder_ctrl_pkg: shared constants, state encoding and captured-operation type for adder_arbiter
package adder_ctrl_pkg;

    localparam int HALF_W = 32;
    localparam int ID_W   = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef struct packed {
        logic [2*HALF_W-1:0] a;
        logic [2*HALF_W-1:0] b;
        logic                cin;
        logic                wide;
    } op_t;

endpackage

// File: rtl/adder32.sv
// adder32: combinational W-bit adder with carry-in and carry-out
module adder32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one adder32 between two requesters, 64-bit adds as two chained passes
module adder_arbiter #(
    parameter int HALF_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_wide,
    input  logic [2*HALF_W-1:0] req0_a,
    input  logic [2*HALF_W-1:0] req0_b,
    input  logic                req0_cin,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_wide,
    input  logic [2*HALF_W-1:0] req1_a,
    input  logic [2*HALF_W-1:0] req1_b,
    input  logic                req1_cin,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [2*HALF_W-1:0] resp_result,
    output logic                resp_cout
);
    import adder_ctrl_pkg::*;

    logic [1:0]          state_q, state_d;
    logic                prio_q, prio_d;
    logic                hold_q, hold_d;
    op_t                 op_q, op_d;
    logic                carry_lo_q, carry_lo_d;
    logic                id_q, id_d;
    logic [2*HALF_W-1:0] result_q, result_d;
    logic                cout_q, cout_d;
    logic                grant0, grant1;
    logic [HALF_W-1:0]   add_a, add_b, add_sum;
    logic                add_cin, add_cout;

    // Round-robin grant; hold_q blocks acceptance in the first IDLE cycle after a response
    always_comb begin
        grant0     = req0_valid && (!prio_q || !req1_valid);
        grant1     = req1_valid && (prio_q || !req0_valid);
        req0_ready = resetn && state_q == ST_IDLE && !hold_q && grant0;
        req1_ready = resetn && state_q == ST_IDLE && !hold_q && grant1;
    end

    // Adder operands: low halves with the request carry in LO, high halves with the chained carry in HI
    always_comb begin
        add_a   = state_q == ST_HI ? op_q.a[2*HALF_W-1:HALF_W] : op_q.a[HALF_W-1:0];
        add_b   = state_q == ST_HI ? op_q.b[2*HALF_W-1:HALF_W] : op_q.b[HALF_W-1:0];
        add_cin = state_q == ST_HI ? carry_lo_q : op_q.cin;
    end

    adder32 #(.W(HALF_W)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Sequencer: capture on accept, one or two adder passes, then hold the result until taken
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        hold_d     = 1'b0;
        op_d       = op_q;
        carry_lo_d = carry_lo_q;
        id_d       = id_q;
        result_d   = result_q;
        cout_d     = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_ready || req1_ready) begin
                    op_d    = req1_ready ? {req1_a, req1_b, req1_cin, req1_wide}
                                         : {req0_a, req0_b, req0_cin, req0_wide};
                    id_d    = req1_ready;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                result_d[HALF_W-1:0] = add_sum;
                carry_lo_d           = add_cout;
                if (!op_q.wide) begin
                    result_d[2*HALF_W-1:HALF_W] = '0;
                    cout_d                      = add_cout;
                end
                state_d = op_q.wide ? ST_HI : ST_RESP;
            end
            ST_HI: begin
                result_d[2*HALF_W-1:HALF_W] = add_sum;
                cout_d                      = add_cout;
                state_d                     = ST_RESP;
            end
            default: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                    prio_d  = ~id_q;
                    hold_d  = 1'b1;
                end
            end
        endcase
    end

    // Registers; reset discards any in-flight operation and returns priority to requester 0
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            prio_q     <= 1'b0;
            hold_q     <= 1'b0;
            op_q       <= '0;
            carry_lo_q <= 1'b0;
            id_q       <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            hold_q     <= hold_d;
            op_q       <= op_d;
            carry_lo_q <= carry_lo_d;
            id_q       <= id_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
        end
    end

    assign resp_valid  = state_q == ST_RESP;
    assign resp_id     = id_q;
    assign resp_result = result_q;
    assign resp_cout   = cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench with a reference arbiter/adder model and randomized requesters
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req0_valid = 1'b0, req0_wide = 1'b0, req0_cin = 1'b0;
    logic        req1_valid = 1'b0, req1_wide = 1'b0, req1_cin = 1'b0;
    logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready;
    logic        resp_valid, resp_id, resp_cout;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_result;

    always #5 clk = ~clk;

    adder_arbiter #(.HALF_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_wide   (req0_wide),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_cin    (req0_cin),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_wide   (req1_wide),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_cin    (req1_cin),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_cout   (resp_cout)
    );

    typedef struct {
        logic        id;
        logic [63:0] res;
        logic        cout;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0, cyc = 0;
    bit   rr_rand = 1'b0, rr_force = 1'b1;
    bit   busy = 1'b0, cool = 1'b0, prio = 1'b0, cur_id = 1'b0;
    int   due = 0;
    bit   was_rst = 1'b0, prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: either forced level or random backpressure
    initial forever begin
        @(posedge clk);
        #1;
        resp_ready = rr_rand ? ($urandom_range(0, 9) < 7) : rr_force;
    end

    // Reference model: who should be ready this cycle, and the expected response of each accept
    always @(negedge clk) begin : model
        logic        e0, e1, w, c;
        logic [63:0] a, b;
        logic [64:0] s;
        logic [32:0] t;
        if (!resetn) begin
            e0 = 1'b0;
            e1 = 1'b0;
        end else begin
            e0 = !busy && !cool && req0_valid && (!prio || !req1_valid);
            e1 = !busy && !cool && req1_valid && (prio || !req0_valid);
        end
        vectors++;
        if ({req0_ready, req1_ready} !== {e0, e1}) begin
            miscompares++;
            $display("FAIL grant cyc=%0d ready0/1 got %b%b expected %b%b", cyc, req0_ready, req1_ready, e0, e1);
        end
        if (!resetn) begin
            busy = 1'b0;
            cool = 1'b0;
            prio = 1'b0;
        end else begin
            cool = 1'b0;
            if (e0 || e1) begin
                a = e1 ? req1_a : req0_a;
                b = e1 ? req1_b : req0_b;
                c = e1 ? req1_cin : req0_cin;
                w = e1 ? req1_wide : req0_wide;
                if (w) s = {1'b0, a} + {1'b0, b} + 65'(c);
                else begin
                    t = {1'b0, a[31:0]} + {1'b0, b[31:0]} + 33'(c);
                    s = {t[32], 32'h0, t[31:0]};
                end
                busy   = 1'b1;
                cur_id = e1;
                due    = cyc + (w ? 3 : 2);
                sb.push_back('{id: e1, res: s[63:0], cout: s[64], due: due});
            end else if (busy && cyc >= due && resp_ready) begin
                busy = 1'b0;
                cool = 1'b1;
                prio = !cur_id;
            end
        end
    end

    // Monitor: compare every presented response with the scoreboard head
    always @(negedge clk) begin : monitor
        if (was_rst) begin
            vectors++;
            if ({resp_valid, resp_id, resp_result, resp_cout} !== 67'd0) begin
                miscompares++;
                $display("FAIL reset_outputs valid=%b id=%b result=%h cout=%b expected all zero",
                         resp_valid, resp_id, resp_result, resp_cout);
            end
        end
        was_rst = !resetn;
        if (!resetn) begin
            sb.delete();
            prev_v = 1'b0;
        end else begin
            if (resp_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_resp cyc=%0d id=%b result=%h", cyc, resp_id, resp_result);
                end else if (resp_id !== sb[0].id || resp_result !== sb[0].res || resp_cout !== sb[0].cout ||
                             (!prev_v && cyc != sb[0].due)) begin
                    miscompares++;
                    $display("FAIL resp cyc=%0d got id=%b result=%h cout=%b expected id=%b result=%h cout=%b due=%0d",
                             cyc, resp_id, resp_result, resp_cout, sb[0].id, sb[0].res, sb[0].cout, sb[0].due);
                end
                if (resp_ready && sb.size() > 0) void'(sb.pop_front());
            end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                vectors++;
                miscompares++;
                $display("FAIL late_resp cyc=%0d resp_valid=0 expected 1 (due %0d)", cyc, sb[0].due);
            end
            prev_v = resp_valid && !resp_ready;
        end
    end

    task automatic drive(input bit r, input bit v, input bit w, input logic [63:0] a, input logic [63:0] b, input bit c);
        if (r) begin
            req1_valid = v; req1_wide = w; req1_a = a; req1_b = b; req1_cin = c;
        end else begin
            req0_valid = v; req0_wide = w; req0_a = a; req0_b = b; req0_cin = c;
        end
    endtask

    // Present one op, wait for its accept, then scramble the inputs the very next cycle
    task automatic issue(input bit r, input bit w, input logic [63:0] a, input logic [63:0] b, input bit c);
        int n = 0;
        drive(r, 1'b1, w, a, b, c);
        forever begin
            @(negedge clk);
            if (r ? req1_ready : req0_ready) break;
            n++;
            if (n > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout req%0d ready=0 expected 1 within 100 cycles", r);
                break;
            end
        end
        @(posedge clk);
        #1;
        drive(r, 1'b0, 1'($urandom_range(0, 1)), {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 4))
            0: return '1;
            1: return '0;
            2: return 64'h0000_0000_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic run_req(input bit r, input int n, input int gap);
        repeat (n) begin
            repeat ($urandom_range(0, gap)) begin
                @(posedge clk);
                #1;
            end
            issue(r, 1'($urandom_range(0, 1)), rnd64(), rnd64(), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        // directed arithmetic corners
        issue(1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
        issue(1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
        issue(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        issue(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        // backpressure with the other requester waiting
        rr_force = 1'b0;
        fork
            issue(1'b0, 1'b0, 64'hAAAA_AAAA_8000_0000, 64'h5555_5555_8000_0000, 1'b1);
            begin
                @(posedge clk);
                #1;
                issue(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                rr_force = 1'b1;
            end
        join
        // reset in the HI pass of a wide op, then both valid: req0 must win
        issue(1'b0, 1'b0, 64'h5, 64'h7, 1'b0);
        issue(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        fork
            issue(1'b0, 1'b0, 64'h1, 64'h2, 1'b0);
            issue(1'b1, 1'b0, 64'h3, 64'h4, 1'b0);
        join
        // continuous round-robin contention
        fork
            run_req(1'b0, 6, 0);
            run_req(1'b1, 6, 0);
        join
        // random traffic with random backpressure
        rr_rand = 1'b1;
        fork
            run_req(1'b0, 40, 6);
            run_req(1'b1, 40, 6);
        join
        rr_rand  = 1'b0;
        rr_force = 1'b1;
        repeat (20) @(posedge clk);
        vectors++;
        if (sb.size() != 0 || busy) begin
            miscompares++;
            $display("FAIL drain pending=%0d busy=%b expected 0 and 0", sb.size(), busy);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
